// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: writeback result-source encodings,
// load funct3 codes and the default datapath width.
package rv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } res_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_pipelined_if.sv
// MEM-to-WB bundle: everything the MEM stage hands to writeback each cycle.
interface wb_stage_pipelined_if #(
    parameter int unsigned XLEN = rv_pkg::XLEN_DEFAULT
);
    logic            ValidM;
    logic            RegWriteM;
    logic [1:0]      ResultSrcM;
    logic [2:0]      Funct3M;
    logic [4:0]      RdM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] ReadDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [XLEN-1:0] ImmExtM;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALUResultM, ReadDataM, PCPlus4M, ImmExtM
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALUResultM, ReadDataM, PCPlus4M, ImmExtM
    );
endinterface

// File: rtl/wb_stage_pipelined_load_extract.sv
// Combinational sub-word load extraction with sign/zero extension.
// Shared with the MEM-stage forwarding path.
module load_extract
    import rv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [XLEN-1:0]  data_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [2:0]       funct3_i,
    output logic [XLEN-1:0]  result_o
);
    localparam int unsigned SW = OFF_W + 3;

    logic [SW-1:0] sh_b, sh_h, sh_w;
    logic [7:0]    b;
    logic [15:0]   h;
    logic [31:0]   w;

    // Masking the bit offset aligns halfword/word lanes; for XLEN=32 the word shift collapses to 0.
    always_comb begin
        sh_b = {off_i, 3'b000};
        sh_h = sh_b & ~SW'(15);
        sh_w = sh_b & ~SW'(31);
        b    = 8'(data_i >> sh_b);
        h    = 16'(data_i >> sh_h);
        w    = 32'(data_i >> sh_w);
    end

    always_comb begin
        result_o = data_i;
        case (funct3_i)
            F3_LB:   result_o = XLEN'($signed(b));
            F3_LBU:  result_o = XLEN'(b);
            F3_LH:   result_o = XLEN'($signed(h));
            F3_LHU:  result_o = XLEN'(h);
            F3_LW:   result_o = XLEN'($signed(w));
            F3_LWU:  result_o = (XLEN == 64) ? XLEN'(w) : XLEN'($signed(w));
            F3_LD:   result_o = (XLEN == 64) ? data_i : XLEN'($signed(w));
            default: result_o = data_i;
        endcase
    end
endmodule

// File: rtl/wb_stage_pipelined.sv
// Writeback stage with the MEM/WB register folded in: stall/flush handling,
// load extraction, gated register-file write and retired-instruction counter.
module wb_stage_pipelined
    import rv_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned LOAD_EXT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallW,
    input  logic                 FlushW,
    wb_stage_pipelined_if.slave  m_if,
    output logic [XLEN-1:0]      ResultW,
    output logic [4:0]           RdW,
    output logic                 RegWriteW,
    output logic                 ValidW,
    output logic [CNT_W-1:0]     InstRetW
);
    localparam int unsigned OFF_W = (XLEN == 64) ? 3 : 2;

    logic            valid_q,      valid_d;
    logic            reg_write_q,  reg_write_d;
    res_src_e        result_src_q, result_src_d;
    logic [2:0]      funct3_q,     funct3_d;
    logic [4:0]      rd_q,         rd_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] read_data_q,  read_data_d;
    logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
    logic [XLEN-1:0] imm_ext_q,    imm_ext_d;
    logic [CNT_W-1:0] instret_q,   instret_d;

    logic [XLEN-1:0] load_val;

    // Retirement depends only on what is already in W, so a flush still retires it.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        pc_plus4_d   = pc_plus4_q;
        imm_ext_d    = imm_ext_q;
        instret_d    = (valid_q && !StallW) ? instret_q + CNT_W'(1) : instret_q;
        if (FlushW) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!StallW) begin
            valid_d      = m_if.ValidM;
            reg_write_d  = m_if.RegWriteM;
            result_src_d = res_src_e'(m_if.ResultSrcM);
            funct3_d     = m_if.Funct3M;
            rd_d         = m_if.RdM;
            alu_result_d = m_if.ALUResultM;
            read_data_d  = m_if.ReadDataM;
            pc_plus4_d   = m_if.PCPlus4M;
            imm_ext_d    = m_if.ImmExtM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= RES_ALU;
            funct3_q     <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
            imm_ext_q    <= '0;
            instret_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_plus4_q   <= pc_plus4_d;
            imm_ext_q    <= imm_ext_d;
            instret_q    <= instret_d;
        end
    end

    load_extract #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_extract (
        .data_i   (read_data_q),
        .off_i    (alu_result_q[OFF_W-1:0]),
        .funct3_i (funct3_q),
        .result_o (load_val)
    );

    always_comb begin
        ResultW = alu_result_q;
        case (result_src_q)
            RES_ALU:  ResultW = alu_result_q;
            RES_LOAD: ResultW = (LOAD_EXT != 0) ? load_val : read_data_q;
            RES_PC4:  ResultW = pc_plus4_q;
            RES_IMM:  ResultW = imm_ext_q;
            default:  ResultW = alu_result_q;
        endcase
    end

    assign RdW       = rd_q;
    assign ValidW    = valid_q;
    assign RegWriteW = reg_write_q & valid_q & (rd_q != '0);
    assign InstRetW  = instret_q;
endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Self-checking bench for wb_stage_pipelined: directed vector table, stall/flush/reset
// sequences, counter wrap on a CNT_W=4 twin, and randomized traffic vs. a reference model.
module tb_wb_stage_pipelined;
    logic clk = 1'b0;
    logic rst;
    logic StallW, FlushW;

    logic [31:0] ResultW, ResultW4;
    logic [4:0]  RdW, RdW4;
    logic        RegWriteW, RegWriteW4, ValidW, ValidW4;
    logic [63:0] InstRetW;
    logic [3:0]  InstRetW4;

    int checks   = 0;
    int failures = 0;

    wb_stage_pipelined_if #(.XLEN(32)) m_if ();

    wb_stage_pipelined #(.XLEN(32), .CNT_W(64), .LOAD_EXT(1)) u_dut (
        .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .m_if(m_if),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .ValidW(ValidW),
        .InstRetW(InstRetW)
    );

    wb_stage_pipelined #(.XLEN(32), .CNT_W(4), .LOAD_EXT(1)) u_dut4 (
        .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .m_if(m_if),
        .ResultW(ResultW4), .RdW(RdW4), .RegWriteW(RegWriteW4), .ValidW(ValidW4),
        .InstRetW(InstRetW4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model state: what W should hold, with the result already resolved.
    logic        m_valid, m_regw;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic [63:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] data, input logic [1:0] off,
                                             input logic [2:0] f3);
        int unsigned o = off;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (data >> (8 * o)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (data >> (16 * (o / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = data;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_result();
        case (m_if.ResultSrcM)
            2'd0:    return m_if.ALUResultM;
            2'd1:    return ref_load(m_if.ReadDataM, m_if.ALUResultM[1:0], m_if.Funct3M);
            2'd2:    return m_if.PCPlus4M;
            default: return m_if.ImmExtM;
        endcase
    endfunction

    task automatic check_outputs();
        check("valid", {63'd0, ValidW}, {63'd0, m_valid});
        check("regwrite", {63'd0, RegWriteW}, {63'd0, m_regw && m_valid && (m_rd != 5'd0)});
        if (m_valid) begin
            check("rd", {59'd0, RdW}, {59'd0, m_rd});
            check("result", {32'd0, ResultW}, {32'd0, m_res});
        end
        check("instret", InstRetW, m_cnt);
        check("instret4", {60'd0, InstRetW4}, m_cnt & 64'hF);
    endtask

    task automatic step();
        @(posedge clk);
        if (!StallW) m_cnt = m_cnt + {63'd0, m_valid};
        if (FlushW) begin
            m_valid = 1'b0;
            m_regw  = 1'b0;
        end else if (!StallW) begin
            m_valid = m_if.ValidM;
            m_regw  = m_if.RegWriteM;
            m_rd    = m_if.RdM;
            m_res   = ref_result();
        end
        #1;
        check_outputs();
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
        m_if.ValidM     = v;
        m_if.RegWriteM  = rw;
        m_if.ResultSrcM = src;
        m_if.Funct3M    = f3;
        m_if.RdM        = rd;
        m_if.ALUResultM = alu;
        m_if.ReadDataM  = rdata;
    endtask

    // Async reset pulse placed mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        StallW = 1'b0;
        FlushW = 1'b0;
        set_m(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        check({tag, "_valid"}, {63'd0, ValidW}, 64'd0);
        check({tag, "_regwrite"}, {63'd0, RegWriteW}, 64'd0);
        check({tag, "_rd"}, {59'd0, RdW}, 64'd0);
        check({tag, "_result"}, {32'd0, ResultW}, 64'd0);
        check({tag, "_instret"}, InstRetW, 64'd0);
        m_valid = 1'b0; m_regw = 1'b0; m_rd = '0; m_res = '0; m_cnt = '0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp_res;
        logic        exp_regw;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rst = 1'b1;
        StallW = 1'b0;
        FlushW = 1'b0;
        set_m(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0);
        m_if.PCPlus4M = 32'h1000_0004;
        m_if.ImmExtM  = 32'hFFFF_F800;
        m_valid = 1'b0; m_regw = 1'b0; m_rd = '0; m_res = '0; m_cnt = '0;

        tbl[0]  = '{2'b00, 3'd0, 5'd7, 1'b1, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1};
        tbl[1]  = '{2'b01, 3'd0, 5'd1, 1'b1, 32'h0000_0103, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b1};
        tbl[2]  = '{2'b01, 3'd4, 5'd2, 1'b1, 32'h0000_0101, 32'h80FF_7F01, 32'h0000_007F, 1'b1};
        tbl[3]  = '{2'b01, 3'd1, 5'd3, 1'b1, 32'h0000_0102, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b1};
        tbl[4]  = '{2'b01, 3'd5, 5'd4, 1'b1, 32'h0000_0100, 32'h80FF_7F01, 32'h0000_7F01, 1'b1};
        tbl[5]  = '{2'b01, 3'd2, 5'd5, 1'b1, 32'h0000_0103, 32'h80FF_7F01, 32'h80FF_7F01, 1'b1};
        tbl[6]  = '{2'b00, 3'd0, 5'd0, 1'b1, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 1'b0};
        tbl[7]  = '{2'b10, 3'd0, 5'd8, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h1000_0004, 1'b1};
        tbl[8]  = '{2'b11, 3'd0, 5'd9, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_F800, 1'b0};
        tbl[9]  = '{2'b01, 3'd3, 5'd10, 1'b1, 32'h0000_0001, 32'h80FF_7F01, 32'h80FF_7F01, 1'b1};
        tbl[10] = '{2'b01, 3'd6, 5'd11, 1'b1, 32'h0000_0003, 32'h80FF_7F01, 32'h80FF_7F01, 1'b1};

        #3;
        check("por_valid", {63'd0, ValidW}, 64'd0);
        check("por_result", {32'd0, ResultW}, 64'd0);
        check("por_instret", InstRetW, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a run, counter at 5.
        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd3, 32'hABCD, 32'd0);
        for (int i = 0; i < 20 && m_cnt != 64'd5; i++) step();
        check("pre_reset_cnt", InstRetW, 64'd5);
        async_reset("midrst");

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            set_m(1'b1, tbl[i].regw, tbl[i].src, tbl[i].f3, tbl[i].rd, tbl[i].alu, tbl[i].rdata);
            step();
            check($sformatf("tbl%0d_result", i), {32'd0, ResultW}, {32'd0, tbl[i].exp_res});
            check($sformatf("tbl%0d_rd", i), {59'd0, RdW}, {59'd0, tbl[i].rd});
            check($sformatf("tbl%0d_regw", i), {63'd0, RegWriteW}, {63'd0, tbl[i].exp_regw});
            check($sformatf("tbl%0d_valid", i), {63'd0, ValidW}, 64'd1);
        end

        // Stall holds W and the counter while M keeps changing.
        async_reset("stlrst");
        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd9, 32'h0000_CAFE, 32'd0);
        step();
        StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_m(1'b1, 1'b1, 2'd3, 3'd0, 5'(i + 20), $urandom, $urandom);
            step();
            check("stall_result", {32'd0, ResultW}, 64'h0000_CAFE);
            check("stall_rd", {59'd0, RdW}, 64'd9);
            check("stall_instret", InstRetW, 64'd0);
        end
        FlushW = 1'b1;
        step();
        check("stflush_valid", {63'd0, ValidW}, 64'd0);
        check("stflush_regw", {63'd0, RegWriteW}, 64'd0);
        check("stflush_instret", InstRetW, 64'd0);
        StallW = 1'b0;
        FlushW = 1'b0;

        // Flush alone still retires the instruction already in W.
        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd4, 32'h77, 32'd0);
        step();
        FlushW = 1'b1;
        step();
        check("flush_retire", InstRetW, 64'd1);
        check("flush_valid", {63'd0, ValidW}, 64'd0);
        FlushW = 1'b0;

        // Counter wrap on the CNT_W=4 instance.
        async_reset("wraprst");
        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd1, 32'h1, 32'd0);
        for (int i = 0; i < 40 && m_cnt != 64'd15; i++) step();
        check("wrap_pre", {60'd0, InstRetW4}, 64'd15);
        step();
        check("wrap_zero", {60'd0, InstRetW4}, 64'd0);
        check("wrap_wide", InstRetW, 64'd16);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            StallW = ($urandom_range(0, 4) == 0);
            FlushW = ($urandom_range(0, 9) == 0);
            set_m(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 3'($urandom),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
            m_if.PCPlus4M = $urandom;
            m_if.ImmExtM  = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
